// File: rtl/atm_ledger_arbiter.sv
// Round-robin arbiter that shares one account ledger between NUM_REQ cashier
// front-ends. Each granted request runs as a single read-modify-write
// (IDLE -> EXEC -> RESP), so concurrent sessions on the same account are
// strictly serialized. A host port preloads balances while the arbiter is idle.
module atm_ledger_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_ACCT = 8,
  parameter int ACCT_W   = 3,
  parameter int BAL_W    = 64,
  parameter int MONTO_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ACCT_W-1:0]   req_acct,
  input  logic [NUM_REQ-1:0]          req_tipo,
  input  logic [NUM_REQ*MONTO_W-1:0]  req_monto,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [BAL_W-1:0]            rsp_balance,
  output logic                        rsp_entregar_dinero,
  output logic                        rsp_fondos_insuficientes,
  output logic                        rsp_saturado,
  input  logic                        init_we,
  input  logic [ACCT_W-1:0]           init_acct,
  input  logic [BAL_W-1:0]            init_balance,
  output logic                        init_ack,
  output logic                        busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [PTR_W-1:0]     rrPtr_q;
  logic [PTR_W-1:0]     winner_q;
  logic [ACCT_W-1:0]    acct_q;
  logic                 tipo_q;
  logic [MONTO_W-1:0]   monto_q;
  logic [BAL_W-1:0]     ledger_q [NUM_ACCT];

  logic [NUM_REQ-1:0]   rspValid_q;
  logic [BAL_W-1:0]     rspBalance_q;
  logic                 entregar_q;
  logic                 fondos_q;
  logic                 saturado_q;
  logic                 initAck_q;

  logic                 grantFound;
  logic [PTR_W-1:0]     grantIdx;
  logic [PTR_W-1:0]     cand;
  logic                 handshake;

  logic [BAL_W-1:0]     balB;
  logic [BAL_W-1:0]     amtM;
  logic [BAL_W:0]       sumExt;
  logic [BAL_W-1:0]     result_d;
  logic                 writeEn_d;
  logic                 entregar_d;
  logic                 fondos_d;
  logic                 saturado_d;

  // Round-robin search: first valid requester after the last winner.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!grantFound && req_valid[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Grant only in IDLE, never while the host is writing or reset is held.
  always_comb begin
    req_ready = '0;
    if (reset && (state_q == IDLE) && !init_we && grantFound) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  assign handshake = |(req_valid & req_ready);

  // Ledger update for the latched transaction; overflow is detected via a carry bit.
  always_comb begin
    balB       = ledger_q[acct_q];
    amtM       = BAL_W'(monto_q);
    sumExt     = {1'b0, balB} + {1'b0, amtM};
    result_d   = balB;
    writeEn_d  = 1'b0;
    entregar_d = 1'b0;
    fondos_d   = 1'b0;
    saturado_d = 1'b0;
    if (tipo_q) begin
      if (amtM > balB) begin
        fondos_d = 1'b1;
      end else begin
        result_d   = balB - amtM;
        writeEn_d  = 1'b1;
        entregar_d = 1'b1;
      end
    end else begin
      writeEn_d = 1'b1;
      if (sumExt[BAL_W]) begin
        result_d   = '1;
        saturado_d = 1'b1;
      end else begin
        result_d = sumExt[BAL_W-1:0];
      end
    end
  end

  // Control FSM with ledger storage and registered response/ack outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= PTR_W'(NUM_REQ - 1);
      winner_q     <= '0;
      acct_q       <= '0;
      tipo_q       <= 1'b0;
      monto_q      <= '0;
      rspValid_q   <= '0;
      rspBalance_q <= '0;
      entregar_q   <= 1'b0;
      fondos_q     <= 1'b0;
      saturado_q   <= 1'b0;
      initAck_q    <= 1'b0;
      for (int a = 0; a < NUM_ACCT; a++) begin
        ledger_q[a] <= '0;
      end
    end else begin
      rspValid_q   <= '0;
      rspBalance_q <= '0;
      entregar_q   <= 1'b0;
      fondos_q     <= 1'b0;
      saturado_q   <= 1'b0;
      initAck_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_we) begin
            ledger_q[init_acct] <= init_balance;
            initAck_q           <= 1'b1;
          end else if (handshake) begin
            winner_q <= grantIdx;
            rrPtr_q  <= grantIdx;
            acct_q   <= req_acct[int'(grantIdx)*ACCT_W +: ACCT_W];
            tipo_q   <= req_tipo[grantIdx];
            monto_q  <= req_monto[int'(grantIdx)*MONTO_W +: MONTO_W];
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          if (writeEn_d) begin
            ledger_q[acct_q] <= result_d;
          end
          rspValid_q[winner_q] <= 1'b1;
          rspBalance_q         <= result_d;
          entregar_q           <= entregar_d;
          fondos_q             <= fondos_d;
          saturado_q           <= saturado_d;
          state_q              <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid                = rspValid_q;
  assign rsp_balance              = rspBalance_q;
  assign rsp_entregar_dinero      = entregar_q;
  assign rsp_fondos_insuficientes = fondos_q;
  assign rsp_saturado             = saturado_q;
  assign init_ack                 = initAck_q;
  assign busy                     = (state_q != IDLE);

endmodule
